// File: rtl/bridge_req_pkg.sv
// Shared types and helpers for the request-side bridge fan-in.
package bridge_req_pkg;

  localparam int unsigned DEF_DATA_WIDTH      = 32;
  localparam int unsigned DEF_ADDR_WIDTH      = 32;
  localparam int unsigned DEF_AUX_WIDTH       = 6;
  localparam int unsigned DEF_BYTE_NUM        = DEF_DATA_WIDTH / 8;
  localparam int unsigned DEF_TAG_WIDTH       = DEF_BYTE_NUM;
  localparam int unsigned DEF_MAX_OUTSTANDING = 4;

  typedef enum logic {
    SRC_CH0 = 1'b0,
    SRC_CH1 = 1'b1
  } src_id_e;

  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0] add;
    logic                      wen;
    logic [DEF_DATA_WIDTH-1:0] wdata;
    logic [DEF_BYTE_NUM-1:0]   be;
    logic [DEF_TAG_WIDTH-1:0]  wtag;
    logic [DEF_AUX_WIDTH-1:0]  aux;
    src_id_e                   id;
  } req_payload_t;

  // Counter must represent 0..max_out inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_out);
    return (max_out < 1) ? 1 : $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/rr_arb_2.sv
// Two-input round-robin arbiter; rr names the channel favoured on contention.
module rr_arb_2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] gnt
);

  logic rr;

  always_comb begin
    gnt = '0;
    if (enable) begin
      if (req == 2'b11) begin
        gnt = rr ? 2'b10 : 2'b01;
      end else begin
        gnt = req;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr <= 1'b0;
    end else if (gnt[0]) begin
      rr <= 1'b1;
    end else if (gnt[1]) begin
      rr <= 1'b0;
    end
  end

endmodule

// File: rtl/fanin_req_arb_bridge.sv
// Merges two request channels into one registered downstream slot with
// round-robin arbitration and an outstanding-transaction limit.
module fanin_req_arb_bridge
  import bridge_req_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int unsigned AUX_WIDTH       = DEF_AUX_WIDTH,
  parameter int unsigned BYTE_NUM        = DATA_WIDTH / 8,
  parameter int unsigned TAG_WIDTH       = BYTE_NUM,
  parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  data_req0_i,
  input  logic [ADDR_WIDTH-1:0] data_add0_i,
  input  logic                  data_wen0_i,
  input  logic [DATA_WIDTH-1:0] data_wdata0_i,
  input  logic [BYTE_NUM-1:0]   data_be0_i,
  input  logic [TAG_WIDTH-1:0]  data_wtag0_i,
  input  logic [AUX_WIDTH-1:0]  data_aux0_i,
  output logic                  data_gnt0_o,

  input  logic                  data_req1_i,
  input  logic [ADDR_WIDTH-1:0] data_add1_i,
  input  logic                  data_wen1_i,
  input  logic [DATA_WIDTH-1:0] data_wdata1_i,
  input  logic [BYTE_NUM-1:0]   data_be1_i,
  input  logic [TAG_WIDTH-1:0]  data_wtag1_i,
  input  logic [AUX_WIDTH-1:0]  data_aux1_i,
  output logic                  data_gnt1_o,

  output logic                  data_req_o,
  output logic [ADDR_WIDTH-1:0] data_add_o,
  output logic                  data_wen_o,
  output logic [DATA_WIDTH-1:0] data_wdata_o,
  output logic [BYTE_NUM-1:0]   data_be_o,
  output logic [TAG_WIDTH-1:0]  data_wtag_o,
  output logic [AUX_WIDTH-1:0]  data_aux_o,
  output logic                  data_ID_o,
  input  logic                  data_gnt_i,
  input  logic                  data_r_valid_i
);

  localparam int unsigned         CNT_W   = cnt_width(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  // Same layout as req_payload_t, but sized from this instance's parameters.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] add;
    logic                  wen;
    logic [DATA_WIDTH-1:0] wdata;
    logic [BYTE_NUM-1:0]   be;
    logic [TAG_WIDTH-1:0]  wtag;
    logic [AUX_WIDTH-1:0]  aux;
    src_id_e               id;
  } slot_t;

  slot_t            slot;
  slot_t            slot_nxt;
  logic             full;
  logic [CNT_W-1:0] count;
  logic             slot_free;
  logic             accept_ok;
  logic [1:0]       arb_req;
  logic [1:0]       arb_gnt;
  logic             inc;
  logic             dec;

  assign slot_free = !full || data_gnt_i;
  // Limit uses the registered count only, so r_valid never feeds gnt.
  assign accept_ok = slot_free && (count < CNT_MAX);
  assign arb_req   = {data_req1_i, data_req0_i};

  rr_arb_2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (arb_req),
    .enable (accept_ok),
    .gnt    (arb_gnt)
  );

  assign data_gnt0_o = arb_gnt[0];
  assign data_gnt1_o = arb_gnt[1];

  assign inc = |arb_gnt;
  assign dec = data_r_valid_i && (count != '0);

  always_comb begin
    slot_nxt.add   = data_add0_i;
    slot_nxt.wen   = data_wen0_i;
    slot_nxt.wdata = data_wdata0_i;
    slot_nxt.be    = data_be0_i;
    slot_nxt.wtag  = data_wtag0_i;
    slot_nxt.aux   = data_aux0_i;
    slot_nxt.id    = SRC_CH0;
    if (arb_gnt[1]) begin
      slot_nxt.add   = data_add1_i;
      slot_nxt.wen   = data_wen1_i;
      slot_nxt.wdata = data_wdata1_i;
      slot_nxt.be    = data_be1_i;
      slot_nxt.wtag  = data_wtag1_i;
      slot_nxt.aux   = data_aux1_i;
      slot_nxt.id    = SRC_CH1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      slot <= '0;
    end else if (inc) begin
      full <= 1'b1;
      slot <= slot_nxt;
    end else if (data_gnt_i) begin
      full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      case ({inc, dec})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign data_req_o   = full;
  assign data_add_o   = slot.add;
  assign data_wen_o   = slot.wen;
  assign data_wdata_o = slot.wdata;
  assign data_be_o    = slot.be;
  assign data_wtag_o  = slot.wtag;
  assign data_aux_o   = slot.aux;
  assign data_ID_o    = slot.id;

endmodule

// File: tb/tb_fanin_req_arb_bridge.sv
// Directed, table-driven bench for fanin_req_arb_bridge (default parameters).
module tb_fanin_req_arb_bridge;

  logic        clk;
  logic        rst_n;
  logic        data_req0_i, data_req1_i;
  logic [31:0] data_add0_i, data_add1_i;
  logic        data_wen0_i, data_wen1_i;
  logic [31:0] data_wdata0_i, data_wdata1_i;
  logic [3:0]  data_be0_i, data_be1_i;
  logic [3:0]  data_wtag0_i, data_wtag1_i;
  logic [5:0]  data_aux0_i, data_aux1_i;
  logic        data_gnt0_o, data_gnt1_o;
  logic        data_req_o;
  logic [31:0] data_add_o;
  logic        data_wen_o;
  logic [31:0] data_wdata_o;
  logic [3:0]  data_be_o;
  logic [3:0]  data_wtag_o;
  logic [5:0]  data_aux_o;
  logic        data_ID_o;
  logic        data_gnt_i;
  logic        data_r_valid_i;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  fanin_req_arb_bridge #(
    .DATA_WIDTH      (32),
    .ADDR_WIDTH      (32),
    .AUX_WIDTH       (6),
    .BYTE_NUM        (4),
    .TAG_WIDTH       (4),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_req0_i    (data_req0_i),
    .data_add0_i    (data_add0_i),
    .data_wen0_i    (data_wen0_i),
    .data_wdata0_i  (data_wdata0_i),
    .data_be0_i     (data_be0_i),
    .data_wtag0_i   (data_wtag0_i),
    .data_aux0_i    (data_aux0_i),
    .data_gnt0_o    (data_gnt0_o),
    .data_req1_i    (data_req1_i),
    .data_add1_i    (data_add1_i),
    .data_wen1_i    (data_wen1_i),
    .data_wdata1_i  (data_wdata1_i),
    .data_be1_i     (data_be1_i),
    .data_wtag1_i   (data_wtag1_i),
    .data_aux1_i    (data_aux1_i),
    .data_gnt1_o    (data_gnt1_o),
    .data_req_o     (data_req_o),
    .data_add_o     (data_add_o),
    .data_wen_o     (data_wen_o),
    .data_wdata_o   (data_wdata_o),
    .data_be_o      (data_be_o),
    .data_wtag_o    (data_wtag_o),
    .data_aux_o     (data_aux_o),
    .data_ID_o      (data_ID_o),
    .data_gnt_i     (data_gnt_i),
    .data_r_valid_i (data_r_valid_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r0, r1, gi, rv;  // inputs for the cycle
    logic        g0, g1;          // combinational grants in the cycle
    logic        rq, id;          // slot state after the edge
    int unsigned cnt;             // outstanding count after the edge
  } vec_t;

  vec_t vecs[26];

  function automatic vec_t mk(logic r0, logic r1, logic gi, logic rv,
                              logic g0, logic g1, logic rq, logic id,
                              int unsigned cnt);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.gi = gi; v.rv = rv;
    v.g0 = g0; v.g1 = g1; v.rq = rq; v.id = id; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r0, input logic r1, input logic gi, input logic rv);
    data_req0_i    = r0;
    data_req1_i    = r1;
    data_gnt_i     = gi;
    data_r_valid_i = rv;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " req_o"}, 64'(data_req_o), 64'd0);
    chk({tag, " gnt"},   64'({data_gnt1_o, data_gnt0_o}), 64'd0);
    chk({tag, " payload"}, 64'({data_add_o, data_wen_o, data_aux_o, data_ID_o}), 64'd0);
    chk({tag, " wdata"}, 64'({data_wdata_o, data_be_o, data_wtag_o}), 64'd0);
  endtask

  task automatic chk_slot(input string tag, input logic id);
    chk({tag, " ID"},   64'(data_ID_o),  64'(id));
    chk({tag, " add"},  64'(data_add_o), id ? 64'h200 : 64'h100);
    chk({tag, " wen"},  64'(data_wen_o), id ? 64'd0 : 64'd1);
    chk({tag, " aux"},  64'(data_aux_o), id ? 64'h2 : 64'h1);
    chk({tag, " data"}, 64'(data_wdata_o), id ? 64'hBBBB1111 : 64'hAAAA0000);
  endtask

  initial begin
    // Table rows: r0 r1 gi rv | g0 g1 | req_o ID | count
    vecs[0]  = mk(0,0,0,0, 0,0, 0,0, 0);
    vecs[1]  = mk(1,1,0,0, 1,0, 1,0, 1);
    vecs[2]  = mk(1,1,1,0, 0,1, 1,1, 2);
    vecs[3]  = mk(1,1,1,1, 1,0, 1,0, 2);
    vecs[4]  = mk(1,1,1,1, 0,1, 1,1, 2);
    vecs[5]  = mk(0,0,1,1, 0,0, 0,0, 1);
    vecs[6]  = mk(0,0,0,1, 0,0, 0,0, 0);
    vecs[7]  = mk(0,0,0,1, 0,0, 0,0, 0);
    vecs[8]  = mk(1,0,0,0, 1,0, 1,0, 1);
    vecs[9]  = mk(1,0,0,0, 0,0, 1,0, 1);
    vecs[10] = mk(1,0,0,0, 0,0, 1,0, 1);
    vecs[11] = mk(1,0,0,0, 0,0, 1,0, 1);
    vecs[12] = mk(1,0,1,0, 1,0, 1,0, 2);
    vecs[13] = mk(0,1,1,0, 0,1, 1,1, 3);
    vecs[14] = mk(1,0,1,0, 1,0, 1,0, 4);
    vecs[15] = mk(1,1,1,0, 0,0, 0,0, 4);
    vecs[16] = mk(1,1,0,1, 0,0, 0,0, 3);
    vecs[17] = mk(1,1,0,0, 0,1, 1,1, 4);
    vecs[18] = mk(1,1,1,0, 0,0, 0,0, 4);
    vecs[19] = mk(0,0,0,1, 0,0, 0,0, 3);
    vecs[20] = mk(0,0,0,1, 0,0, 0,0, 2);
    vecs[21] = mk(0,0,0,1, 0,0, 0,0, 1);
    vecs[22] = mk(0,0,0,1, 0,0, 0,0, 0);
    vecs[23] = mk(1,0,0,1, 1,0, 1,0, 1);
    vecs[24] = mk(0,0,1,1, 0,0, 0,0, 0);
    vecs[25] = mk(0,0,0,1, 0,0, 0,0, 0);

    rst_n = 1'b0;
    drive(0, 0, 0, 0);
    data_add0_i = 32'h100;      data_add1_i = 32'h200;
    data_wen0_i = 1'b1;         data_wen1_i = 1'b0;
    data_wdata0_i = 32'hAAAA0000; data_wdata1_i = 32'hBBBB1111;
    data_be0_i = 4'hF;          data_be1_i = 4'h3;
    data_wtag0_i = 4'h1;        data_wtag1_i = 4'h2;
    data_aux0_i = 6'h1;         data_aux1_i = 6'h2;

    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("in_reset");
    chk("in_reset count", 64'(dut.count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_all_zero($sformatf("idle%0d", i));
    end

    @(posedge clk);
    #1;
    for (int i = 0; i < 26; i++) begin
      drive(vecs[i].r0, vecs[i].r1, vecs[i].gi, vecs[i].rv);
      @(negedge clk);
      chk($sformatf("v%0d gnt0", i), 64'(data_gnt0_o), 64'(vecs[i].g0));
      chk($sformatf("v%0d gnt1", i), 64'(data_gnt1_o), 64'(vecs[i].g1));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d req_o", i), 64'(data_req_o), 64'(vecs[i].rq));
      chk($sformatf("v%0d count", i), 64'(dut.count), 64'(vecs[i].cnt));
      if (vecs[i].rq) chk_slot($sformatf("v%0d", i), vecs[i].id);
    end

    // Fill slot with count=3 (rr favours ch1 after last ch0 grant), then reset mid-flight.
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 0);
      @(negedge clk);
      chk($sformatf("pre_rst%0d gnt", i), 64'({data_gnt1_o, data_gnt0_o}),
          (i == 1) ? 64'b01 : 64'b10);
      @(posedge clk);
      #1;
    end
    drive(0, 0, 0, 0);
    chk("pre_rst req_o", 64'(data_req_o), 64'd1);
    chk("pre_rst count", 64'(dut.count), 64'd3);
    chk_slot("pre_rst", 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst req_o", 64'(data_req_o), 64'd0);
    chk("async_rst count", 64'(dut.count), 64'd0);
    chk("async_rst rr", 64'(dut.u_arb.rr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Responses still in flight from before reset must not underflow.
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1);
      @(posedge clk);
      #1;
      chk($sformatf("post_rst%0d count", i), 64'(dut.count), 64'd0);
      chk($sformatf("post_rst%0d req_o", i), 64'(data_req_o), 64'd0);
    end

    // Contention right after reset goes to ch0 first.
    drive(1, 1, 0, 0);
    @(negedge clk);
    chk("post_rst arb gnt", 64'({data_gnt1_o, data_gnt0_o}), 64'b01);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0);
    chk_slot("post_rst slot", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
